// File: rtl/dm_initiator.sv
// Memory-stage initiator: turns CPU load/store requests into word-wide req/ack
// bus transactions, with read-merge-write for sub-word stores and lane-extracted loads.
module dm_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] MRG  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [2:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [1:0]    off_q, off_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic          cpu_err_q, cpu_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          misaligned;
  logic          ack;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input logic [1:0] size, input logic sgn);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: extract = {{24{sgn & lane[7]}}, lane[7:0]};
      SZ_HALF: extract = {{16{sgn & lane[15]}}, lane[15:0]};
      default: extract = word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] off,
                                        input logic [1:0] size, input logic [15:0] data);
    logic [31:0] mask;
    logic [4:0]  sh;
    sh   = {off, 3'b000};
    mask = (size == SZ_BYTE) ? (32'h0000_00FF << sh) : (32'h0000_FFFF << sh);
    merge = (word & ~mask) | (({16'h0000, data} << sh) & mask);
  endfunction

  assign misaligned = (cpu_size == 2'b11)
                    | ((cpu_size == SZ_HALF) & cpu_addr[0])
                    | ((cpu_size == SZ_WORD) & (|cpu_addr[1:0]));

  // An ack is only meaningful while a transaction is actually on the bus.
  assign ack         = mem_req_q & mem_ack;
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a signal unassigned (no latches).
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_err_d   = cpu_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d        = cpu_we;
          size_d      = cpu_size;
          signed_d    = cpu_signed;
          off_d       = cpu_addr[1:0];
          wdata_d     = cpu_wdata[15:0];
          cpu_rdata_d = '0;
          cpu_err_d   = 1'b0;
          if (misaligned) begin
            cpu_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            mem_addr_d = {cpu_addr[31:2], 2'b00};
            mem_req_d  = 1'b1;
            cnt_d      = '0;
            if (cpu_we && (cpu_size == SZ_WORD)) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = cpu_wdata;
              state_d     = WR;
            end else begin
              mem_we_d = 1'b0;
              state_d  = RD;
            end
          end
        end
      end
      RD: begin
        if (ack) begin
          mem_req_d = 1'b0;
          if (we_q) begin
            mem_wdata_d = merge(mem_rdata, off_q, size_q, wdata_q);
            state_d     = MRG;
          end else begin
            cpu_rdata_d = extract(mem_rdata, off_q, size_q, signed_q);
            state_d     = RESP;
          end
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          cpu_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MRG: begin
        mem_req_d = 1'b1;
        mem_we_d  = 1'b1;
        cnt_d     = '0;
        state_d   = WR;
      end
      WR: begin
        if (ack || timeout_hit) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cpu_err_d = ~ack;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      off_q       <= '0;
      wdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      cpu_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_err_q   <= cpu_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cpu_done  = (state_q == RESP);
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_done;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_initiator.sv
// Self-checking bench for dm_initiator: behavioural memory with wait states,
// scoreboard queues for CPU responses and memory writes.
module tb_dm_initiator;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_signed = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_err;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dm_initiator #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_size  (cpu_size),
    .cpu_signed(cpu_signed),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_err   (cpu_err),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    bit          chk_rd;
    bit          err;
    int          lat;
    string       tag;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t sb[$];
  wr_t  wr_q[$];

  logic [31:0] mem [0:63];
  int  wait_cfg  = 0;
  bit  no_ack_rd = 1'b0;
  bit  no_ack_wr = 1'b0;
  int  wait_cnt  = 0;
  int  rd_cnt    = 0;
  int  wr_cnt    = 0;

  logic [31:0] last_trace;
  int          last_req_cycles;

  // Memory responder: drives ack/rdata on the falling edge, DUT samples on the rising edge.
  always @(negedge clk) begin
    wr_t w;
    if (!reset || !mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if ((mem_we ? no_ack_wr : no_ack_rd) || (wait_cnt < wait_cfg)) begin
      mem_ack = 1'b0;
      wait_cnt++;
    end else begin
      mem_ack = 1'b1;
      if (mem_we) begin
        wr_cnt++;
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", mem_addr, w.addr);
          check("wr_data", mem_wdata, w.data);
        end
        mem[mem_addr[7:2]] = mem_wdata;
      end else begin
        rd_cnt++;
        mem_rdata = mem[mem_addr[7:2]];
      end
    end
  end

  task automatic run(input string tag, input bit we, input logic [1:0] size, input bit sgn,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input bit chk_rd, input bit exp_err,
                     input int exp_lat);
    exp_t        e;
    int          cyc;
    int          req_cycles;
    bit          got;
    bit          stall_bad;
    logic [31:0] trace;
    e.rd = exp_rd; e.chk_rd = chk_rd; e.err = exp_err; e.lat = exp_lat; e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_signed = sgn;
    cpu_addr = addr; cpu_wdata = wdata;
    cyc = 0; got = 1'b0; stall_bad = 1'b0; req_cycles = 0; trace = '0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        if (cyc < 32) trace[cyc] = 1'b1;
      end
      if (cpu_done) got = 1'b1;
      else begin
        if (!cpu_stall) stall_bad = 1'b1;
        cyc++;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      check({e.tag, "_done_seen"}, 32'd0, 32'd1);
    end else begin
      check({e.tag, "_err"}, cpu_err, e.err);
      if (e.chk_rd) check({e.tag, "_rdata"}, cpu_rdata, e.rd);
      if (e.lat >= 0) check({e.tag, "_latency"}, cyc, e.lat);
      check({e.tag, "_stall_before_done"}, stall_bad, 1'b0);
      check({e.tag, "_stall_at_done"}, cpu_stall, 1'b0);
      check({e.tag, "_mem_req_at_done"}, mem_req, 1'b0);
    end
    last_trace      = trace;
    last_req_cycles = req_cycles;
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r0;
    int  w0;
    bit  found;
    wr_t w;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h8899AABB;
    mem[8]  = 32'hFFFFFFFF;
    mem[12] = 32'h01234567;

    repeat (3) @(negedge clk);
    check("rst_mem_req",   mem_req,   32'd0);
    check("rst_mem_we",    mem_we,    32'd0);
    check("rst_cpu_done",  cpu_done,  32'd0);
    check("rst_cpu_err",   cpu_err,   32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_mem_addr",  mem_addr,  32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b1;

    // Loads, zero-wait memory.
    run("ld_w_10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b1, 1'b0, 2);
    check("ld_w_req_cycle1", last_trace[1], 32'd1);
    run("ld_bs_11",  1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b1, 1'b0, 2);
    run("ld_bu_11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h000000AA, 1'b1, 1'b0, 2);
    run("ld_hs_12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8899, 1'b1, 1'b0, 2);
    run("ld_hu_10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000AABB, 1'b1, 1'b0, 2);
    run("ld_bs_10",  1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b1, 1'b0, 2);

    // Byte store via read-merge-write.
    r0 = rd_cnt; w0 = wr_cnt;
    w.addr = 32'h10; w.data = 32'h5599AABB; wr_q.push_back(w);
    run("st_b_13",   1'b1, 2'b00, 1'b0, 32'h13, 32'h00000055, 32'h0, 1'b0, 1'b0, 4);
    check("st_b_reads",        rd_cnt - r0,   32'd1);
    check("st_b_writes",       wr_cnt - w0,   32'd1);
    check("st_b_req_cycle1",   last_trace[1], 32'd1);
    check("st_b_req_low_mrg",  last_trace[2], 32'd0);
    check("st_b_req_cycle3",   last_trace[3], 32'd1);
    run("ld_back_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h5599AABB, 1'b1, 1'b0, 2);

    // Word store: single write, no read.
    r0 = rd_cnt;
    w.addr = 32'h24; w.data = 32'hCAFEF00D; wr_q.push_back(w);
    run("st_w_24",   1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 2);
    check("st_w_no_read", rd_cnt - r0, 32'd0);
    run("ld_hu_26",  1'b0, 2'b01, 1'b0, 32'h26, 32'h0, 32'h0000CAFE, 1'b1, 1'b0, 2);

    // Wait states: ack arrives in the fourth cycle of each transaction.
    wait_cfg = 3;
    w.addr = 32'h20; w.data = 32'hFFFF1234; wr_q.push_back(w);
    run("st_h_20_wait", 1'b1, 2'b01, 1'b0, 32'h20, 32'hABCD1234, 32'h0, 1'b0, 1'b0, 10);
    run("ld_w_20_wait", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hFFFF1234, 1'b1, 1'b0, 5);
    wait_cfg = 0;

    // Misaligned accesses never reach memory.
    r0 = rd_cnt; w0 = wr_cnt;
    run("mis_w_22",  1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 1'b1, 1);
    check("mis_w_no_req", last_req_cycles, 32'd0);
    run("mis_h_11",  1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1, 1'b1, 1);
    run("mis_sz3_st", 1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0, 1'b1, 1);
    check("mis_sz3_no_req", last_req_cycles, 32'd0);
    check("mis_no_mem_traffic", (rd_cnt - r0) + (wr_cnt - w0), 32'd0);

    // Timeout: memory never acks.
    no_ack_rd = 1'b1;
    run("timeout_ld", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 1'b1, -1);
    check("timeout_req_cycles", last_req_cycles, TO);
    no_ack_rd = 1'b0;

    // Reset while a write is outstanding.
    no_ack_wr = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b00; cpu_signed = 1'b0;
    cpu_addr = 32'h31; cpu_wdata = 32'h000000EE;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) found = 1'b1;
    end
    check("rst_reached_wr", found, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_mem_req",   mem_req,   32'd0);
    check("rst_mid_mem_we",    mem_we,    32'd0);
    check("rst_mid_mem_wdata", mem_wdata, 32'd0);
    check("rst_mid_mem_addr",  mem_addr,  32'd0);
    check("rst_mid_cpu_done",  cpu_done,  32'd0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    no_ack_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_after_no_done", cpu_done, 32'd0);
      check("rst_after_no_req",  mem_req,  32'd0);
    end
    run("ld_after_rst", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h01234567, 1'b1, 1'b0, 2);
    run("ld_bu_31",     1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 32'h00000045, 1'b1, 1'b0, 2);

    check("sb_empty",   sb.size(),   32'd0);
    check("wr_q_empty", wr_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
